pipeline_issue_ctrl: RTL and testbench

PIPELINE_ISSUE_CTRL -- requirements
Module: pipeline_issue_ctrl

---
 rtl/pipeline_issue_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pipeline_issue_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_issue_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_issue_ctrl
//
// In-order issue stage for a three-deep execute pipeline with no forwarding.
// One instruction is held in a head register.  It is issued to the datapath
// only when none of its source registers is still being written by one of the
// three instructions issued before it.  Those writers are tracked in the
// S1..S3 scoreboard.  While a hazard persists the block emits bubbles and
// counts stall cycles.  A small RUN/DRAIN/IDLE FSM lets the system stop intake
// and wait until every in-flight write has retired.
//
// Ports
//   clk        in   1   clock, all state on the rising edge
//   rst        in   1   asynchronous active-low reset
//   in_instr   in  32   [31:26] opcode, [25:21] WS1, [20:16] RS1, [15:11] RS2,
//                       [10:0] imm
//   in_valid   in   1   source has an instruction
//   in_ready   out  1   head can take an instruction this cycle
//   drain_req  in   1   level request to stop intake and empty the pipeline
//   flush      in   1   synchronous discard of the head and the scoreboard
//   out_instr  out 32   registered instruction to the datapath (0 for a bubble)
//   out_valid  out  1   out_instr carries a real instruction
//   stall      out  1   the current bubble was caused by a hazard
//   drained    out  1   FSM is in IDLE (intake stopped, pipeline empty)
//   issue_cnt  out 16   saturating count of issued instructions
//   stall_cnt  out 16   saturating count of hazard stall cycles
// ----------------------------------------------------------------------------
module pipeline_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        drain_req,
    input  logic        flush,
    output logic [31:0] out_instr,
    output logic        out_valid,
    output logic        stall,
    output logic        drained,
    output logic [15:0] issue_cnt,
    output logic [15:0] stall_cnt
);

    localparam logic [5:0]  OpMov  = 6'b010000;
    localparam logic [5:0]  OpNot  = 6'b010001;
    localparam logic [15:0] CntMax = 16'hFFFF;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StIdle  = 2'd2
    } state_e;

    state_e state_q;

    // Head register: the single pending instruction.
    logic        head_valid_q;
    logic [31:0] head_instr_q;

    // Scoreboard: index 0 is S1 (most recently issued), index 2 is S3.
    logic [2:0]      sb_valid_q;
    logic [2:0][4:0] sb_dest_q;

    // ------------------------------------------------------------------
    // Head decode
    // ------------------------------------------------------------------
    logic [5:0] head_op;
    logic [4:0] head_ws;
    logic [4:0] head_rs1;
    logic [4:0] head_rs2;
    logic       head_is_alu;
    logic       head_uses_rs2;

    assign head_op  = head_instr_q[31:26];
    assign head_ws  = head_instr_q[25:21];
    assign head_rs1 = head_instr_q[20:16];
    assign head_rs2 = head_instr_q[15:11];

    // Anything outside the ALU group is a NOP: no destination, no sources.
    assign head_is_alu = (head_op[5:4] == 2'b01);

    // Immediate forms (opcode[3]=1) and the unary MOV/NOT only read RS1.
    assign head_uses_rs2 = head_is_alu && !head_op[3] &&
                           (head_op != OpMov) && (head_op != OpNot);

    // ------------------------------------------------------------------
    // Hazard detection against every valid scoreboard stage.
    // R0 is an ordinary register here, so it is compared like any other.
    // ------------------------------------------------------------------
    logic [2:0] stage_hit;
    logic       hazard;

    always_comb begin
        stage_hit = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (sb_valid_q[i]) begin
                if (head_is_alu && (head_rs1 == sb_dest_q[i])) begin
                    stage_hit[i] = 1'b1;
                end
                if (head_uses_rs2 && (head_rs2 == sb_dest_q[i])) begin
                    stage_hit[i] = 1'b1;
                end
            end
        end
    end

    assign hazard = head_valid_q && (stage_hit != 3'b000);

    // ------------------------------------------------------------------
    // Issue / accept decisions.  flush overrides both.
    // ------------------------------------------------------------------
    logic issue;
    logic stall_now;
    logic accept;

    assign issue     = head_valid_q && !hazard && !flush;
    assign stall_now = hazard && !flush;

    // The head can be refilled in the same cycle it issues.
    assign in_ready  = (state_q == StRun) && !flush && (!head_valid_q || issue);
    assign accept    = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Control FSM with registered drained flag.
    // flush freezes the FSM except that a drain request still leaves RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            drained <= 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    if (drain_req) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!flush && !head_valid_q && (sb_valid_q == 3'b000)) begin
                        state_q <= StIdle;
                        drained <= 1'b1;
                    end
                end
                StIdle: begin
                    if (!flush && !drain_req) begin
                        state_q <= StRun;
                        drained <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StRun;
                    drained <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Head register and scoreboard
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_valid_q <= 1'b0;
            head_instr_q <= 32'h0;
            sb_valid_q   <= 3'b000;
            sb_dest_q    <= '0;
        end else if (flush) begin
            head_valid_q <= 1'b0;
            sb_valid_q   <= 3'b000;
        end else begin
            // Shift S1->S2->S3; S1 takes the issuing ALU op's destination.
            sb_valid_q <= {sb_valid_q[1:0], issue && head_is_alu};
            sb_dest_q  <= {sb_dest_q[1], sb_dest_q[0], head_ws};

            if (accept) begin
                head_valid_q <= 1'b1;
                head_instr_q <= in_instr;
            end else if (issue) begin
                head_valid_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered datapath outputs and saturating counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_instr <= 32'h0;
            out_valid <= 1'b0;
            stall     <= 1'b0;
            issue_cnt <= 16'h0;
            stall_cnt <= 16'h0;
        end else begin
            out_valid <= issue;
            out_instr <= issue ? head_instr_q : 32'h0;
            stall     <= stall_now;

            if (issue && (issue_cnt != CntMax)) begin
                issue_cnt <= issue_cnt + 16'd1;
            end
            if (stall_now && (stall_cnt != CntMax)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
module tb_pipeline_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        drain_req = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] out_instr;
    logic        out_valid;
    logic        stall;
    logic        drained;
    logic [15:0] issue_cnt;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipeline_issue_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_instr  (in_instr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .drain_req (drain_req),
        .flush     (flush),
        .out_instr (out_instr),
        .out_valid (out_valid),
        .stall     (stall),
        .drained   (drained),
        .issue_cnt (issue_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] ws,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [10:0] imm);
        return {op, ws, rs1, rs2, imm};
    endfunction

    // Instruction words
    logic [31:0] mov_r2_r1, not_r3_r4, add_r11_r10_r5, add_r3_r2_r5, addi_r11, subi_r12;
    logic [31:0] add_r9_r7_r8, sub_r12_r11_r15, add_r5_r6_r3, mov_r7_r6, nop_w2;
    logic [31:0] mov_r0_r1, mov_r4_r0;

    // Program and per-cycle log
    logic [31:0] prog [8];
    int          prog_n;
    logic        log_v [16];
    logic [31:0] log_i [16];
    logic        log_s [16];
    logic        exp_v [16];
    logic [31:0] exp_i [16];
    logic        exp_s [16];

    task automatic do_reset();
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        flush     = 1'b0;
        drain_req = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Feed prog[0..prog_n-1] with in_valid held high, logging outputs #1 after each edge.
    task automatic run_prog(input int ncyc);
        int  idx;
        logic take;
        idx = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (idx < prog_n) begin
                in_valid = 1'b1;
                in_instr = prog[idx];
            end else begin
                in_valid = 1'b0;
                in_instr = 32'h0;
            end
            #1;
            take = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (take) idx++;
            log_v[c] = out_valid;
            log_i[c] = out_instr;
            log_s[c] = stall;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_instr = 32'h0;
        checks++;
        if (idx !== prog_n) begin
            errors++;
            $display("FAIL prog_consumed: accepted %0d instructions, expected %0d", idx, prog_n);
        end
    endtask

    task automatic set_exp(input int c, input logic v, input logic [31:0] i, input logic s);
        exp_v[c] = v;
        exp_i[c] = i;
        exp_s[c] = s;
    endtask

    // Expected stream: idle, first, [mid], nb stall bubbles, second, idle.
    task automatic exp_stream(input logic [31:0] first, input logic has_mid,
                              input logic [31:0] mid, input int nb, input logic [31:0] second);
        int c;
        set_exp(0, 1'b0, 32'h0, 1'b0);
        set_exp(1, 1'b1, first, 1'b0);
        c = 2;
        if (has_mid) begin
            set_exp(c, 1'b1, mid, 1'b0);
            c++;
        end
        for (int b = 0; b < nb; b++) begin
            set_exp(c, 1'b0, 32'h0, 1'b1);
            c++;
        end
        set_exp(c, 1'b1, second, 1'b0);
        set_exp(c + 1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_instr, out_valid, stall, drained} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs: got instr=%h v=%b s=%b d=%b, expected all 0",
                     out_instr, out_valid, stall, drained);
        end
        checks++;
        if (issue_cnt !== 16'h0 || stall_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_counters: got issue=%0d stall=%0d, expected 0 0",
                     issue_cnt, stall_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_independent();
        do_reset();
        prog[0] = mov_r2_r1; prog[1] = not_r3_r4; prog[2] = add_r11_r10_r5; prog_n = 3;
        run_prog(5);
        set_exp(0, 1'b0, 32'h0, 1'b0);
        set_exp(1, 1'b1, mov_r2_r1, 1'b0);
        set_exp(2, 1'b1, not_r3_r4, 1'b0);
        set_exp(3, 1'b1, add_r11_r10_r5, 1'b0);
        set_exp(4, 1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (log_v[c] !== exp_v[c] || log_i[c] !== exp_i[c] || log_s[c] !== exp_s[c]) begin
                errors++;
                $display("FAIL independent cyc%0d: got v=%b i=%h s=%b, expected v=%b i=%h s=%b",
                         c, log_v[c], log_i[c], log_s[c], exp_v[c], exp_i[c], exp_s[c]);
            end
        end
        checks++;
        if (issue_cnt !== 16'd3 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL independent_counts: got issue=%0d stall=%0d, expected 3 0",
                     issue_cnt, stall_cnt);
        end
    endtask

    // Run a producer/consumer pair (optionally with one instruction between).
    task automatic pair_case(input string name, input logic [31:0] first, input logic has_mid,
                             input logic [31:0] mid, input int nb, input logic [31:0] second);
        int n;
        do_reset();
        prog[0] = first;
        if (has_mid) begin
            prog[1] = mid; prog[2] = second; prog_n = 3;
        end else begin
            prog[1] = second; prog_n = 2;
        end
        n = 4 + nb + (has_mid ? 1 : 0);
        run_prog(n);
        exp_stream(first, has_mid, mid, nb, second);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (log_v[c] !== exp_v[c] || log_i[c] !== exp_i[c] || log_s[c] !== exp_s[c]) begin
                errors++;
                $display("FAIL %s cyc%0d: got v=%b i=%h s=%b, expected v=%b i=%h s=%b",
                         name, c, log_v[c], log_i[c], log_s[c], exp_v[c], exp_i[c], exp_s[c]);
            end
        end
        checks++;
        if (stall_cnt !== 16'(nb) || issue_cnt !== 16'(prog_n)) begin
            errors++;
            $display("FAIL %s_counts: got issue=%0d stall=%0d, expected %0d %0d",
                     name, issue_cnt, stall_cnt, prog_n, nb);
        end
    endtask

    task automatic test_raw_adjacent();
        pair_case("raw_adjacent", mov_r2_r1, 1'b0, 32'h0, 3, add_r3_r2_r5);
    endtask

    task automatic test_hazard_variants();
        pair_case("imm_pair", addi_r11, 1'b0, 32'h0, 3, subi_r12);
        pair_case("one_between", addi_r11, 1'b1, add_r9_r7_r8, 2, sub_r12_r11_r15);
        pair_case("rs2_source", not_r3_r4, 1'b0, 32'h0, 3, add_r5_r6_r3);
        pair_case("nop_no_write", nop_w2, 1'b0, 32'h0, 0, add_r3_r2_r5);
        pair_case("r0_ordinary", mov_r0_r1, 1'b0, 32'h0, 3, mov_r4_r0);
    endtask

    task automatic test_drain();
        do_reset();
        prog[0] = add_r11_r10_r5; prog_n = 1;
        run_prog(2);
        checks++;
        if (log_v[1] !== 1'b1 || log_i[1] !== add_r11_r10_r5) begin
            errors++;
            $display("FAIL drain_issue: got v=%b i=%h, expected v=1 i=%h",
                     log_v[1], log_i[1], add_r11_r10_r5);
        end
        drain_req = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || drained !== 1'b0) begin
            errors++;
            $display("FAIL drain_enter: got in_ready=%b drained=%b, expected 0 0",
                     in_ready, drained);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = mov_r2_r1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (drained !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain_wait%0d: got drained=%b in_ready=%b v=%b, expected 0 0 0",
                         c, drained, in_ready, out_valid);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (drained !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: got drained=%b in_ready=%b v=%b, expected 1 0 0",
                     drained, in_ready, out_valid);
        end
        @(negedge clk);
        drain_req = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (drained !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_resume: got drained=%b in_ready=%b v=%b, expected 0 1 0",
                     drained, in_ready, out_valid);
        end
        in_valid = 1'b0;
        in_instr = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        do_reset();
        prog[0] = mov_r2_r1; prog[1] = add_r3_r2_r5; prog_n = 2;
        run_prog(3);
        checks++;
        if (log_v[2] !== 1'b0 || log_s[2] !== 1'b1) begin
            errors++;
            $display("FAIL flush_prestall: got v=%b s=%b, expected v=0 s=1", log_v[2], log_s[2]);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = mov_r7_r6;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b, expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_bubble: got v=%b i=%h s=%b, expected 0 0 0",
                     out_valid, out_instr, stall);
        end
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard: got v=%b i=%h s=%b, expected v=0 s=0",
                     out_valid, out_instr, stall);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_instr = 32'h0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== mov_r7_r6 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_next_issue: got v=%b i=%h s=%b, expected 1 %h 0",
                     out_valid, out_instr, stall, mov_r7_r6);
        end
        checks++;
        if (issue_cnt !== 16'd2 || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL flush_counts: got issue=%0d stall=%0d, expected 2 1",
                     issue_cnt, stall_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        prog[0] = mov_r2_r1; prog[1] = add_r3_r2_r5; prog_n = 2;
        run_prog(3);
        checks++;
        if (stall !== 1'b1 || stall_cnt !== 16'd1 || issue_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rst_mid_pre: got s=%b stall_cnt=%0d issue_cnt=%0d, expected 1 1 1",
                     stall, stall_cnt, issue_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({out_instr, out_valid, stall, drained} !== 35'h0 ||
            issue_cnt !== 16'h0 || stall_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_async: got i=%h v=%b s=%b d=%b ic=%0d sc=%0d, expected all 0",
                     out_instr, out_valid, stall, drained, issue_cnt, stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_in_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || issue_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_no_issue: got v=%b i=%h ic=%0d, expected 0 0 0",
                     out_valid, out_instr, issue_cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        mov_r2_r1       = mk(6'b010000, 5'd2, 5'd1, 5'd0, 11'd0);
        not_r3_r4       = mk(6'b010001, 5'd3, 5'd4, 5'd0, 11'd0);
        add_r11_r10_r5  = mk(6'b010010, 5'd11, 5'd10, 5'd5, 11'd0);
        add_r3_r2_r5    = mk(6'b010010, 5'd3, 5'd2, 5'd5, 11'd0);
        addi_r11        = mk(6'b011000, 5'd11, 5'd6, 5'd0, 11'd413);
        subi_r12        = mk(6'b011001, 5'd12, 5'd11, 5'd0, 11'd413);
        add_r9_r7_r8    = mk(6'b010010, 5'd9, 5'd7, 5'd8, 11'd0);
        sub_r12_r11_r15 = mk(6'b010011, 5'd12, 5'd11, 5'd15, 11'd0);
        add_r5_r6_r3    = mk(6'b010010, 5'd5, 5'd6, 5'd3, 11'd0);
        mov_r7_r6       = mk(6'b010000, 5'd7, 5'd6, 5'd0, 11'd0);
        nop_w2          = mk(6'b000000, 5'd2, 5'd0, 5'd0, 11'd0);
        mov_r0_r1       = mk(6'b010000, 5'd0, 5'd1, 5'd0, 11'd0);
        mov_r4_r0       = mk(6'b010000, 5'd4, 5'd0, 5'd0, 11'd0);

        test_reset();
        test_independent();
        test_raw_adjacent();
        test_hazard_variants();
        test_drain();
        test_flush();
        test_reset_mid_stall();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
